// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared checkpoint types for branch recovery
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif

package nand_cpu_pkg;

  localparam int NUM_CKPT_DEF = 4;
  localparam int ROB_SIZE_DEF = `ROB_SIZE;
  localparam int CKPT_ID_W    = $clog2(NUM_CKPT_DEF);
  localparam int ROB_TAIL_W   = $clog2(ROB_SIZE_DEF);

  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

  typedef struct packed {
    logic                  valid;
    logic                  resolved;
    logic [ROB_TAIL_W-1:0] tail;
  } ckpt_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RESTORE,
    FLUSH
  } ckpt_state_e;

  // Age relative to the oldest live checkpoint; smaller is older.
  function automatic ckpt_id_t ckpt_age(input ckpt_id_t id, input ckpt_id_t head);
    return id - head;
  endfunction

endpackage

// File: rtl/ckpt_age_compare.sv
// rtl/ckpt_age_compare.sv - is checkpoint a older than b, measured from head
module ckpt_age_compare #(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] head_i,
  output logic         older_o
);

  logic [W-1:0] age_a;
  logic [W-1:0] age_b;

  assign age_a   = a_i - head_i;
  assign age_b   = b_i - head_i;
  assign older_o = age_a < age_b;

endmodule

// File: rtl/branch_checkpoint_manager.sv
// rtl/branch_checkpoint_manager.sv - in-order branch checkpoints and ROB restore sequencing
module branch_checkpoint_manager
  import nand_cpu_pkg::*;
#(
  parameter int NUM_CKPT     = NUM_CKPT_DEF,
  parameter int ROB_L        = `ROB_SIZE,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        alloc_req,
  input  logic [$clog2(ROB_L)-1:0]    alloc_tail,
  output logic                        alloc_grant,
  output logic [$clog2(NUM_CKPT)-1:0] alloc_id,
  output logic                        stall,
  input  logic                        resolve_valid,
  input  logic [$clog2(NUM_CKPT)-1:0] resolve_id,
  input  logic                        resolve_mispredict,
  output logic                        restore,
  output logic [$clog2(ROB_L)-1:0]    restore_tail,
  output logic [$clog2(NUM_CKPT)-1:0] restore_id,
  output logic [$clog2(NUM_CKPT):0]   num_active
);

  localparam int IW = $clog2(NUM_CKPT);
  localparam int TW = $clog2(ROB_L);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IW:0] FULL = (IW+1)'(NUM_CKPT);

  ckpt_entry_t       entry_q [NUM_CKPT];
  logic [IW-1:0]     head_q, head_d;
  logic [IW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [IW:0]       count_q, count_d;
  ckpt_state_e       state_q;
  logic [FW-1:0]     flush_cnt_q;
  logic              restore_q;
  logic [TW-1:0]     restore_tail_q;
  logic [IW-1:0]     restore_id_q;

  logic              mp_active, mp_accept, older_than_restore;
  logic              resolve_ok, retire;
  logic [IW-1:0]     age_mp;
  logic [NUM_CKPT-1:0] keep, squash;

  assign mp_active  = resolve_valid & resolve_mispredict & entry_q[resolve_id].valid;
  assign resolve_ok = resolve_valid & ~resolve_mispredict & entry_q[resolve_id].valid;

  // A nested mispredict only matters if it is older than the one being recovered.
  ckpt_age_compare #(.W(IW)) u_override (
    .a_i     (resolve_id),
    .b_i     (restore_id_q),
    .head_i  (head_q),
    .older_o (older_than_restore)
  );

  assign mp_accept = mp_active & ((state_q == IDLE) | older_than_restore);

  for (genvar i = 0; i < NUM_CKPT; i++) begin : g_squash
    ckpt_age_compare #(.W(IW)) u_sq (
      .a_i     (IW'(i)),
      .b_i     (resolve_id),
      .head_i  (head_q),
      .older_o (keep[i])
    );
    assign squash[i] = mp_accept & ~keep[i];
  end

  assign retire      = entry_q[head_q].valid & entry_q[head_q].resolved & ~squash[head_q];
  assign age_mp      = ckpt_age(resolve_id, head_q);
  assign alloc_grant = alloc_req & (state_q == IDLE) & (count_q < FULL) & ~mp_active;
  assign alloc_id    = alloc_ptr_q;
  assign stall       = (count_q == FULL) | (state_q != IDLE);

  // A surviving head retire in the squash cycle still leaves the table, so it
  // is taken off the age-based count.
  always_comb begin
    head_d      = head_q + IW'(retire);
    alloc_ptr_d = alloc_ptr_q + IW'(alloc_grant);
    count_d     = count_q + (IW+1)'(alloc_grant) - (IW+1)'(retire);
    if (mp_accept) begin
      alloc_ptr_d = resolve_id;
      count_d     = {1'b0, age_mp} - (IW+1)'(retire);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_CKPT; i++) entry_q[i] <= '0;
      head_q         <= '0;
      alloc_ptr_q    <= '0;
      count_q        <= '0;
      state_q        <= IDLE;
      flush_cnt_q    <= '0;
      restore_q      <= 1'b0;
      restore_tail_q <= '0;
      restore_id_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (squash[i]) begin
          entry_q[i] <= '0;
        end else if (retire && head_q == IW'(i)) begin
          entry_q[i] <= '0;
        end else if (resolve_ok && resolve_id == IW'(i)) begin
          entry_q[i].resolved <= 1'b1;
        end else if (alloc_grant && alloc_ptr_q == IW'(i)) begin
          entry_q[i].valid    <= 1'b1;
          entry_q[i].resolved <= 1'b0;
          entry_q[i].tail     <= alloc_tail;
        end
      end
      head_q      <= head_d;
      alloc_ptr_q <= alloc_ptr_d;
      count_q     <= count_d;
      restore_q   <= 1'b0;
      if (mp_accept) begin
        state_q        <= RESTORE;
        restore_q      <= 1'b1;
        restore_tail_q <= entry_q[resolve_id].tail;
        restore_id_q   <= resolve_id;
      end else begin
        case (state_q)
          RESTORE: begin
            state_q     <= FLUSH;
            flush_cnt_q <= FW'(FLUSH_CYCLES - 1);
          end
          FLUSH: begin
            if (flush_cnt_q == '0) state_q <= IDLE;
            else flush_cnt_q <= flush_cnt_q - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign restore      = restore_q;
  assign restore_tail = restore_tail_q;
  assign restore_id   = restore_id_q;
  assign num_active   = count_q;

endmodule

// File: doc/branch_checkpoint_manager.md
Name: branch_checkpoint_manager

Overview:
- Schedules ROB recovery for branch speculation.
- Allocates an in-order checkpoint per dispatched branch and stores the ROB tail snapshot with it.
- Retires checkpoints in order as branches resolve correctly.
- On a mispredict, sequences the restore pulse consumed by reorder_buffer (checkpoint.restore / checkpoint.tail) and stalls dispatch during recovery.
- Sits between decode/dispatch, the branch-resolve path of execute, and reorder_buffer.

Parameters:
- NUM_CKPT, 4, number of checkpoint slots; power of two, ≥2.
- ROB_L, `ROB_SIZE, ROB depth; snapshot width is $clog2(ROB_L).
- FLUSH_CYCLES, 2, dispatch-stall cycles after the restore pulse.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; synchronous, active-low.
- alloc_req  in  1  dispatch presents a branch this cycle.
- alloc_tail  in  $clog2(ROB_L)  ROB tail to restore to if this branch mispredicts.
- alloc_grant  out  1  combinational; branch accepted this cycle.
- alloc_id  out  $clog2(NUM_CKPT)  combinational; checkpoint id assigned (valid when alloc_grant).
- stall  out  1  combinational; dispatch must hold.
- resolve_valid  in  1  a branch resolved this cycle.
- resolve_id  in  $clog2(NUM_CKPT)  checkpoint id of the resolved branch.
- resolve_mispredict  in  1  1 = mispredicted, 0 = correct.
- restore  out  1  registered one-cycle pulse to reorder_buffer.
- restore_tail  out  $clog2(ROB_L)  registered snapshot accompanying restore.
- restore_id  out  $clog2(NUM_CKPT)  registered id being recovered.
- num_active  out  $clog2(NUM_CKPT)+1  registered count of live checkpoints.

Behaviour:
- Storage: circular table indexed by id; each entry holds valid, resolved, tail.
- Pointers: head = oldest, alloc_ptr = next free, count = live entries. All pointer arithmetic is modulo NUM_CKPT.
- Reset (n_rst=0 at posedge): head=alloc_ptr=count=0, all valid/resolved=0, state=IDLE, flush counter=0, restore=0, restore_tail=0, restore_id=0, num_active=0.
- An id is active when valid=1. Age is (id - head) mod NUM_CKPT; smaller is older.
- alloc_grant = alloc_req & state==IDLE & count<NUM_CKPT & ~(resolve_valid & resolve_mispredict & active(resolve_id)).
- alloc_id = alloc_ptr.
- stall = (count==NUM_CKPT) | state!=IDLE.
- Full check uses the registered count. A head retire in the same cycle does not free a slot for that cycle's alloc.
- Grant at posedge: entry[alloc_ptr] ← {valid=1, resolved=0, tail=alloc_tail}; alloc_ptr+1.
- Correct resolve on an active id sets resolved=1. Accepted in every state. Resolve on an inactive id is ignored.
- Retire: each cycle, if entry[head] valid & resolved, clear it and advance head. At most one retire per cycle. A resolve and a retire of the same head entry cannot occur in the same cycle; resolved must be registered first.
- Mispredict accept condition: active id, and either state==IDLE, or state!=IDLE with the id older than the registered restore_id. Otherwise ignored.
- Mispredict accept action (one cycle latency):
  - next cycle restore=1, restore_tail=entry[id].tail, restore_id=id.
  - entry id and all younger active entries cleared.
  - alloc_ptr ← id.
  - count ← age(id).
  - state → RESTORE.
- FSM:
  - IDLE → RESTORE on accepted mispredict.
  - RESTORE (restore=1 for exactly this one cycle) → FLUSH, flush counter ← FLUSH_CYCLES-1.
  - FLUSH decrements the counter and → IDLE at 0.
  - An accepted older mispredict in RESTORE or FLUSH → RESTORE again, with a new pulse on the following cycle.
- count = registered; next value = count + grant - retire, except on mispredict where the rule above wins. num_active mirrors count.
- Wrap-around: alloc_ptr and head wrap from NUM_CKPT-1 to 0. Full is distinguished from empty by count, not by pointer equality.
- Simultaneous events:
  - Mispredict beats alloc in the same cycle (no grant).
  - A correct resolve in the same cycle as a mispredict is applied only if its id survives the squash.
- Reset mid-recovery aborts immediately to the reset state; restore is 0 on the next cycle.

Decomposition:
- Shared package nand_cpu_pkg holds:
  - ckpt_id_t
  - the ckpt_entry_t packed struct {valid, resolved, tail}
  - the ckpt_state_e enum {IDLE, RESTORE, FLUSH}
- rob_checkpoint interface gains restore_id alongside restore and tail.
- One natural sub-module, ckpt_age_compare: combinational, returns older(a, b, head); used for squash masking and the mispredict-override test.

Test Plan:
- Reset, then alloc 4 branches with tails 3,5,9,12 → alloc_id 0..3; num_active=4; stall=1; a 5th alloc_req gets alloc_grant=0.
- Correct-resolve ids 1 then 0 → id 0 retires the cycle after its resolve, id 1 the cycle after that; num_active goes 4→3→2; stall drops.
- Mispredict id 1 with tails {0:3, 1:5, 2:9} → next cycle restore=1, restore_tail=5, restore_id=1, num_active=1. Then stall held for 1+FLUSH_CYCLES=3 cycles, next alloc gets id 1.
- During FLUSH after mispredict id 2, mispredict id 0 → new restore pulse with tail of id 0; num_active=0; mispredict of squashed id 3 ignored.
- Wrap: allocate/retire 6 branches with NUM_CKPT=4 → alloc_id sequence 0,1,2,3,0,1; full/empty correct at head=alloc_ptr=2.
- Assert n_rst=0 in the RESTORE cycle → next cycle restore=0, num_active=0, state IDLE, alloc_id=0.
